// File: rtl/vec_ram_stream_rd.sv
// Read-side streaming engine for vec_ram: issues sequential 8-byte reads and
// returns the words as a valid/ready stream with a last marker.
module vec_ram_stream_rd #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 64,
    parameter int STRB_W     = 8,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ram_en_o,
    output logic [STRB_W-1:0] ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [DATA_W-1:0] ram_d_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  issue_rem;
    logic [LEN_W-1:0]  out_rem;
    logic              inflight;

    logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;

    logic [OCC_W-1:0]  occupancy;
    logic [ADDR_W-1:0] issue_addr;
    logic [LEN_W-1:0]  issue_cnt;
    logic              issue;
    logic              push;
    logic              pop;
    logic              pop_last;

    // Occupancy counts the FIFO, the read landing now and the read just issued,
    // so a new issue can never find the FIFO full when its data arrives.
    always_comb begin
        occupancy  = OCC_W'(fifo_count) + OCC_W'(inflight) + OCC_W'(ram_en_o);
        issue_addr = (state == ST_IDLE) ? base_addr_i : addr;
        issue_cnt  = (state == ST_IDLE) ? len_i : issue_rem;
        issue      = ((state == ST_IDLE) && start_i && (len_i != '0)) ||
                     ((state == ST_RUN) && (issue_rem != '0) &&
                      (occupancy < OCC_W'(FIFO_DEPTH)));
        push       = (state == ST_RUN) && inflight;
        pop        = m_valid_o && m_ready_i;
        pop_last   = pop && m_last_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            addr       <= '0;
            issue_rem  <= '0;
            out_rem    <= '0;
            inflight   <= 1'b0;
            ram_en_o   <= 1'b0;
            ram_addr_o <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_last  <= '0;
        end else begin
            ram_en_o <= issue;
            inflight <= ram_en_o;

            if (issue) begin
                ram_addr_o <= issue_addr;
                addr       <= issue_addr + ADDR_W'(8);
                issue_rem  <= issue_cnt - LEN_W'(1);
            end

            if (push) begin
                fifo_last[wr_ptr] <= (out_rem == LEN_W'(1));
                wr_ptr            <= wr_ptr + PTR_W'(1);
                out_rem           <= out_rem - LEN_W'(1);
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        out_rem <= len_i;
                        state   <= (len_i != '0) ? ST_RUN : ST_FIN;
                    end
                end
                ST_RUN: begin
                    if (pop_last) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr] <= ram_d_i;
        end
    end

    assign busy_o    = (state == ST_RUN);
    assign done_o    = (state == ST_FIN);
    assign ram_we_o  = '0;
    assign m_valid_o = (fifo_count != '0);
    assign m_data_o  = m_valid_o ? fifo_data[rd_ptr] : '0;
    assign m_last_o  = m_valid_o && fifo_last[rd_ptr];

endmodule

// File: tb/tb_vec_ram_stream_rd.sv
// Directed self-checking bench for vec_ram_stream_rd with a behavioural
// vec_ram whose byte at address a holds a[7:0]-0x10.
module tb_vec_ram_stream_rd;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [23:0] base_addr_i;
    logic [15:0] len_i;
    logic        busy_o;
    logic        done_o;
    logic        ram_en_o;
    logic [7:0]  ram_we_o;
    logic [23:0] ram_addr_o;
    logic [63:0] ram_d_i = '0;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [63:0] m_data_o;
    logic        m_last_o;

    int check_cnt = 0;
    int pass_cnt  = 0;

    int          cyc = 0;
    int          last_start_cyc = -100;
    int          last_done_cyc = -100;
    int          done_cnt = 0;
    int          busy_cnt = 0;
    int          we_bad = 0;
    int          stall_bad = 0;
    int          outstanding = 0;
    int          max_out = 0;
    logic        stall_prev = 1'b0;
    logic [63:0] prev_data = '0;
    logic        prev_last = 1'b0;

    logic [23:0] addr_q[$];
    int          en_cyc_q[$];
    logic [63:0] rx_data_q[$];
    logic        rx_last_q[$];
    int          hs_cyc_q[$];

    vec_ram_stream_rd dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_d_i     (ram_d_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .m_last_o    (m_last_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] word_at(input logic [23:0] a);
        logic [63:0] w;
        logic [23:0] b;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            b = a + 24'(k);
            w = {w[55:0], b[7:0] - 8'h10};
        end
        return w;
    endfunction

    always @(posedge clk_i) begin
        if (ram_en_o) ram_d_i <= word_at(ram_addr_o);
    end

    // Monitor samples mid-cycle, where inputs and outputs are both settled.
    always @(negedge clk_i) begin
        cyc++;
        if (rst_i) begin
            outstanding = 0;
        end else begin
            if (start_i && !busy_o && !done_o) last_start_cyc = cyc;
            if (ram_en_o) begin
                addr_q.push_back(ram_addr_o);
                en_cyc_q.push_back(cyc);
                outstanding++;
            end
            if (m_valid_o && m_ready_i) begin
                rx_data_q.push_back(m_data_o);
                rx_last_q.push_back(m_last_o);
                hs_cyc_q.push_back(cyc);
                outstanding--;
            end
            if (outstanding > max_out) max_out = outstanding;
            if (done_o) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (busy_o) busy_cnt++;
            if (stall_prev && (!m_valid_o || m_data_o != prev_data || m_last_o != prev_last))
                stall_bad++;
        end
        if (ram_we_o != '0) we_bad++;
        stall_prev = !rst_i && m_valid_o && !m_ready_i;
        prev_data  = m_data_o;
        prev_last  = m_last_o;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input logic [23:0] base, input logic [15:0] len);
        @(posedge clk_i); #1;
        start_i     = 1'b1;
        base_addr_i = base;
        len_i       = len;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int done_before, input int pat, input int budget);
        int k;
        k = 0;
        while (k < budget && done_cnt == done_before) begin
            m_ready_i = (pat == 0) ? 1'b1 : (k % 3 == 0);
            @(posedge clk_i); #1;
            k++;
        end
        if (done_cnt == done_before) checkOutput("done_timeout", 64'd1, 64'd0);
        m_ready_i = 1'b1;
        repeat (6) @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, "_ctrl"}, 64'({busy_o, done_o, ram_en_o, m_valid_o, m_last_o}), 64'd0);
        checkOutput({tag, "_addr"}, 64'(ram_addr_o), 64'd0);
        checkOutput({tag, "_data"}, m_data_o, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [23:0] exp_addr1 [4];
        logic [63:0] exp_data1 [4];
        logic [23:0] exp_addr4 [3];
        logic [7:0]  lastv;
        int e0, r0, d0, b0, s, n;

        exp_addr1 = '{24'h000010, 24'h000018, 24'h000020, 24'h000028};
        exp_data1 = '{64'h0001020304050607, 64'h08090A0B0C0D0E0F,
                      64'h1011121314151617, 64'h18191A1B1C1D1E1F};
        exp_addr4 = '{24'hFFFFF8, 24'h000000, 24'h000008};

        rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; len_i = '0; m_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("reset");

        // Test 1: len=4 full throughput
        e0 = addr_q.size(); r0 = rx_data_q.size(); d0 = done_cnt;
        applyStimulus(24'h000010, 16'd4);
        wait_done(d0, 0, 40);
        s = last_start_cyc;
        checkOutput("t1_en_count", 64'(addr_q.size() - e0), 64'd4);
        checkOutput("t1_rx_count", 64'(rx_data_q.size() - r0), 64'd4);
        lastv = '0;
        for (int i = 0; i < 4; i++) begin
            if (addr_q.size() > e0 + i) begin
                checkOutput("t1_addr", 64'(addr_q[e0+i]), 64'(exp_addr1[i]));
                checkOutput("t1_en_cycle", 64'(en_cyc_q[e0+i]), 64'(s + 1 + i));
            end
            if (rx_data_q.size() > r0 + i) begin
                checkOutput("t1_data", rx_data_q[r0+i], exp_data1[i]);
                lastv[i] = rx_last_q[r0+i];
            end
        end
        checkOutput("t1_last_flags", 64'(lastv), 64'h08);
        if (hs_cyc_q.size() >= r0 + 4) begin
            checkOutput("t1_first_valid_cycle", 64'(hs_cyc_q[r0]), 64'(s + 3));
            checkOutput("t1_done_cycle", 64'(last_done_cyc), 64'(hs_cyc_q[r0+3] + 1));
        end
        checkOutput("t1_done_count", 64'(done_cnt - d0), 64'd1);

        // Test 2: len=8 with ready pattern 1,0,0
        e0 = addr_q.size(); r0 = rx_data_q.size(); d0 = done_cnt; b0 = stall_bad;
        applyStimulus(24'h000040, 16'd8);
        wait_done(d0, 1, 200);
        checkOutput("t2_rx_count", 64'(rx_data_q.size() - r0), 64'd8);
        checkOutput("t2_en_count", 64'(addr_q.size() - e0), 64'd8);
        lastv = '0;
        n = rx_data_q.size() - r0;
        for (int i = 0; i < 8; i++) begin
            if (n > i) begin
                checkOutput("t2_data", rx_data_q[r0+i], word_at(24'h000040 + 24'(8 * i)));
                lastv[i] = rx_last_q[r0+i];
            end
        end
        checkOutput("t2_last_flags", 64'(lastv), 64'h80);
        checkOutput("t2_outstanding_le_depth", 64'(max_out <= 4), 64'd1);
        checkOutput("t2_stall_stable_errors", 64'(stall_bad - b0), 64'd0);
        checkOutput("t2_done_count", 64'(done_cnt - d0), 64'd1);

        // Test 3: len=0
        e0 = addr_q.size(); d0 = done_cnt; b0 = busy_cnt;
        applyStimulus(24'h000080, 16'd0);
        wait_done(d0, 0, 20);
        checkOutput("t3_en_count", 64'(addr_q.size() - e0), 64'd0);
        checkOutput("t3_done_count", 64'(done_cnt - d0), 64'd1);
        checkOutput("t3_done_cycle", 64'(last_done_cyc), 64'(last_start_cyc + 1));
        checkOutput("t3_busy_cycles", 64'(busy_cnt - b0), 64'd0);

        // Test 4: address wrap
        e0 = addr_q.size(); r0 = rx_data_q.size(); d0 = done_cnt;
        applyStimulus(24'hFFFFF8, 16'd3);
        wait_done(d0, 0, 40);
        checkOutput("t4_en_count", 64'(addr_q.size() - e0), 64'd3);
        checkOutput("t4_rx_count", 64'(rx_data_q.size() - r0), 64'd3);
        lastv = '0;
        for (int i = 0; i < 3; i++) begin
            if (addr_q.size() > e0 + i)
                checkOutput("t4_addr", 64'(addr_q[e0+i]), 64'(exp_addr4[i]));
            if (rx_data_q.size() > r0 + i) begin
                checkOutput("t4_data", rx_data_q[r0+i], word_at(exp_addr4[i]));
                lastv[i] = rx_last_q[r0+i];
            end
        end
        checkOutput("t4_last_flags", 64'(lastv), 64'h04);

        // Test 5: reset after the second delivered word
        r0 = rx_data_q.size(); d0 = done_cnt;
        applyStimulus(24'h000100, 16'd6);
        n = 0;
        while (n < 50 && rx_data_q.size() < r0 + 2) begin
            @(posedge clk_i); #1;
            n++;
        end
        checkOutput("t5_two_words_seen", 64'(rx_data_q.size() >= r0 + 2), 64'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("t5_after_reset");
        repeat (10) @(posedge clk_i);
        #1;
        checkOutput("t5_no_done", 64'(done_cnt - d0), 64'd0);
        r0 = rx_data_q.size(); d0 = done_cnt;
        applyStimulus(24'h000000, 16'd1);
        wait_done(d0, 0, 30);
        checkOutput("t5_restart_rx_count", 64'(rx_data_q.size() - r0), 64'd1);
        if (rx_data_q.size() > r0) begin
            checkOutput("t5_restart_data", rx_data_q[r0], 64'hF0F1F2F3F4F5F6F7);
            checkOutput("t5_restart_last", 64'(rx_last_q[r0]), 64'd1);
        end
        checkOutput("t5_restart_done", 64'(done_cnt - d0), 64'd1);

        // Test 6: second start while busy is ignored
        e0 = addr_q.size(); r0 = rx_data_q.size(); d0 = done_cnt;
        applyStimulus(24'h000020, 16'd2);
        start_i = 1'b1; base_addr_i = 24'h000200; len_i = 16'd9;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        wait_done(d0, 0, 40);
        repeat (20) @(posedge clk_i);
        #1;
        checkOutput("t6_en_count", 64'(addr_q.size() - e0), 64'd2);
        checkOutput("t6_rx_count", 64'(rx_data_q.size() - r0), 64'd2);
        lastv = '0;
        for (int i = 0; i < 2; i++) begin
            if (rx_data_q.size() > r0 + i) begin
                checkOutput("t6_data", rx_data_q[r0+i], word_at(24'h000020 + 24'(8 * i)));
                lastv[i] = rx_last_q[r0+i];
            end
        end
        checkOutput("t6_last_flags", 64'(lastv), 64'h02);
        checkOutput("t6_done_count", 64'(done_cnt - d0), 64'd1);
        checkOutput("we_never_set", 64'(we_bad), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
